ad5541_spi_rx_monitor: RTL



---
 rtl/ad5541_pkg.sv | 18 +
 rtl/sync_edge_det.sv | 56 +++++
 rtl/ad5541_spi_rx_monitor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ad5541_pkg.sv
// Shared definitions for the AD5541 DAC SPI path.
// Contents: system/DAC constants and the receive-monitor FSM state encoding.
package ad5541_pkg;

    parameter int unsigned CLK_HZ           = 10_000_000;
    parameter int unsigned AD5541_WORD_BITS = 16;
    parameter int unsigned DA_NUMS          = 1524;
    parameter int unsigned CODE_SEGS        = 11;

    // WAIT_HIGH: hold off until cs is seen idle, so a word cut by reset is never captured.
    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        CHECK     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Input synchroniser with optional edge detection.
// Ports:
//   clk_10m  in   system clock
//   rst_n    in   synchronous active-low reset (chain resets to 1, the SPI idle level)
//   din      in   asynchronous input
//   level    out  synchronised level
//   rise     out  1-cycle pulse on synchronised 0->1 (0 when EDGE_EN=0)
//   fall     out  1-cycle pulse on synchronised 1->0 (0 when EDGE_EN=0)
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_EN     = 1'b1
) (
    input  logic clk_10m,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic level_d;

            always_ff @(posedge clk_10m) begin
                if (!rst_n) begin
                    level_d <= 1'b1;
                end else begin
                    level_d <= level;
                end
            end

            assign rise = level & ~level_d;
            assign fall = ~level & level_d;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ad5541_spi_rx_monitor.sv
// AD5541 SPI receive monitor: reconstructs 16-bit MSB-first words from an oversampled
// cs/sclk/mosi bus, flags transfers of the wrong length and delimits frames by cs-high gaps.
// Ports:
//   clk_10m        in   10 MHz system clock
//   rst_n          in   synchronous active-low reset
//   sclk           in   SPI clock, idle high, data sampled on rising edge
//   mosi           in   SPI data
//   cs             in   chip select, active-low
//   o_data         out  last good word, held until the next good word
//   o_valid        out  1-cycle pulse when o_data is updated
//   o_err_len      out  1-cycle pulse on a transfer with edge count != WORD_BITS
//   o_word_cnt     out  good words in the current frame (saturating)
//   o_err_cnt      out  length errors since reset (saturating)
//   o_frame_done   out  1-cycle pulse when an idle gap ends a non-empty frame
//   o_frame_words  out  o_word_cnt captured at o_frame_done
module ad5541_spi_rx_monitor
    import ad5541_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WORD_BITS   = AD5541_WORD_BITS,
    parameter int unsigned GAP_CYCLES  = CLK_HZ / 10_000
) (
    input  logic        clk_10m,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_err_len,
    output logic [15:0] o_word_cnt,
    output logic [7:0]  o_err_cnt,
    output logic        o_frame_done,
    output logic [15:0] o_frame_words
);

    localparam logic [10:0] GapMax   = 11'(GAP_CYCLES);
    localparam logic [4:0]  WordBits = 5'(WORD_BITS);
    localparam int unsigned SettleW  = $clog2(SYNC_STAGES + 1);
    localparam logic [SettleW-1:0] SettleMax = SettleW'(SYNC_STAGES);

    logic s_cs, cs_rise, cs_fall;
    logic sclk_rise;
    logic s_mosi;
    logic unused_sclk_level, unused_sclk_fall;
    logic unused_mosi_rise, unused_mosi_fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_EN     (1'b1)
    ) u_cs_sync (
        .clk_10m (clk_10m),
        .rst_n   (rst_n),
        .din     (cs),
        .level   (s_cs),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_EN     (1'b1)
    ) u_sclk_sync (
        .clk_10m (clk_10m),
        .rst_n   (rst_n),
        .din     (sclk),
        .level   (unused_sclk_level),
        .rise    (sclk_rise),
        .fall    (unused_sclk_fall)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_EN     (1'b0)
    ) u_mosi_sync (
        .clk_10m (clk_10m),
        .rst_n   (rst_n),
        .din     (mosi),
        .level   (s_mosi),
        .rise    (unused_mosi_rise),
        .fall    (unused_mosi_fall)
    );

    rx_state_e          state;
    logic [15:0]        shreg;
    logic [4:0]         bitcnt;
    logic [10:0]        gap_cnt;
    // The sync chain resets to 1, so s_cs reads high for SYNC_STAGES cycles after reset
    // regardless of the pin; WAIT_HIGH only trusts s_cs once the chain holds real samples.
    logic [SettleW-1:0] settle_cnt;

    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            state         <= WAIT_HIGH;
            shreg         <= '0;
            bitcnt        <= '0;
            gap_cnt       <= '0;
            settle_cnt    <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_err_len     <= 1'b0;
            o_word_cnt    <= '0;
            o_err_cnt     <= '0;
            o_frame_done  <= 1'b0;
            o_frame_words <= '0;
        end else begin
            o_valid      <= 1'b0;
            o_err_len    <= 1'b0;
            o_frame_done <= 1'b0;

            if (!s_cs) begin
                gap_cnt <= '0;
            end

            case (state)
                WAIT_HIGH: begin
                    if (settle_cnt != SettleMax) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else if (s_cs) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (cs_fall) begin
                        shreg  <= '0;
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end else if (s_cs && (gap_cnt != GapMax)) begin
                        gap_cnt <= gap_cnt + 11'd1;
                        // Counter saturates at GapMax, so this fires once per gap.
                        if ((gap_cnt == GapMax - 11'd1) && (o_word_cnt != 16'd0)) begin
                            o_frame_done  <= 1'b1;
                            o_frame_words <= o_word_cnt;
                            o_word_cnt    <= '0;
                        end
                    end
                end

                SHIFT: begin
                    // cs_rise wins over a coincident sclk_rise: that edge is dropped.
                    if (cs_rise) begin
                        state <= CHECK;
                    end else if (sclk_rise) begin
                        shreg <= {shreg[14:0], s_mosi};
                        if (bitcnt != 5'd31) begin
                            bitcnt <= bitcnt + 5'd1;
                        end
                    end
                end

                CHECK: begin
                    gap_cnt <= '0;
                    if (bitcnt == WordBits) begin
                        o_data  <= shreg;
                        o_valid <= 1'b1;
                        if (o_word_cnt != 16'hFFFF) begin
                            o_word_cnt <= o_word_cnt + 16'd1;
                        end
                    end else begin
                        o_err_len <= 1'b1;
                        if (o_err_cnt != 8'hFF) begin
                            o_err_cnt <= o_err_cnt + 8'd1;
                        end
                    end
                    state <= IDLE;
                end

                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule
